// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide with a final sign-fix cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [5:0] LAST = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]      op_q;
    logic            neg_q;
    logic            rneg_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] dvs_q;
    logic [5:0]      cnt_q;

    logic [2:0]      op_n;
    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            accept;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_val;

    assign op_n   = alu_sel[5:3];
    assign is_div = op_n[2];
    assign accept = (state_q == IDLE) && start && (alu_sel[2:0] == 3'b001);

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (op_n)
            3'd1: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'd2: a_sgn = 1'b1;
            3'd4, 3'd6: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            default: ;
        endcase
    end

    assign sa    = a_sgn & op_a[XLEN-1];
    assign sb    = b_sgn & op_b[XLEN-1];
    assign a_mag = sa ? -op_a : op_a;
    assign b_mag = sb ? -op_b : op_b;

    assign div_zero = is_div && (op_b == '0);
    assign ovf      = is_div && !op_n[0] && (op_a == SMIN) && (op_b == '1);
    assign special  = div_zero | ovf;

    // REM/REMU have op_n[1] set; DIV/DIVU clear.
    always_comb begin
        spec_val = '0;
        unique case (1'b1)
            div_zero && !op_n[1]: spec_val = '1;
            div_zero && op_n[1]:  spec_val = op_a;
            !div_zero && !op_n[1]: spec_val = SMIN;
            default:              spec_val = '0;
        endcase
    end

    // One iteration of either datapath.
    logic [XLEN:0]   msum;
    logic [XLEN:0]   dsh;
    logic            dge;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;

    assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    assign dsh  = {hi_q, lo_q[XLEN-1]};
    assign dge  = dsh >= {1'b0, dvs_q};

    always_comb begin
        hi_n = '0;
        lo_n = '0;
        if (op_q[2]) begin
            hi_n = dge ? XLEN'(dsh - {1'b0, dvs_q}) : dsh[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], dge};
        end else begin
            hi_n = msum[XLEN:1];
            lo_n = {msum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = neg_q ? -lo_q : lo_q;
    assign rem    = rneg_q ? -hi_q : hi_q;

    always_comb begin
        fix_val = '0;
        unique case (1'b1)
            !op_q[2] && (op_q[1:0] == 2'd0): fix_val = prod_s[XLEN-1:0];
            !op_q[2] && (op_q[1:0] != 2'd0): fix_val = prod_s[2*XLEN-1:XLEN];
            op_q[2] && !op_q[1]:             fix_val = quo;
            default:                         fix_val = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else if (accept) begin
            op_q   <= op_n;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            dvs_q  <= is_div ? b_mag : a_mag;
            cnt_q  <= '0;
            if (special) begin
                result <= spec_val;
            end
        end else if (state_q == CALC) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 6'd1;
        end else if (state_q == FIX) begin
            result <= fix_val;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Directed RV32M vectors; a negedge monitor checks every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  alu_sel = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_sel(alu_sel),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          passed = 0;
    logic [31:0] last_res = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(logic [5:0] sel, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp, int lat, bit push);
        @(posedge clk);
        #1;
        start   = 1'b1;
        alu_sel = sel;
        op_a    = a;
        op_b    = b;
        if (push) begin
            sbq.push_back('{exp, cyc + lat});
            last_res = exp;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        alu_sel = '0;
        op_a    = '0;
        op_b    = '0;
    endtask

    task automatic wait_idle(string name, int exp_n);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(6'b000001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1);
        wait_idle("busy_mul", 34);
        issue(6'b001001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1);
        wait_idle("busy_mulh", 34);
        issue(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
        wait_idle("busy_mulhu", 34);
        issue(6'b010001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1);
        wait_idle("busy_mulhsu", 34);
        issue(6'b100001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1);
        wait_idle("busy_div", 34);
        issue(6'b110001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1);
        wait_idle("busy_rem", 34);
        issue(6'b101001, 32'd100, 32'd7, 32'd14, 34, 1);
        wait_idle("busy_divu", 34);
        issue(6'b111001, 32'd100, 32'd7, 32'd2, 34, 1);
        wait_idle("busy_remu", 34);

        issue(6'b100001, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1);
        wait_idle("busy_div0", 1);
        issue(6'b111001, 32'd5, 32'd0, 32'd5, 1, 1);
        wait_idle("busy_remu0", 1);
        issue(6'b100001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
        wait_idle("busy_divovf", 1);
        issue(6'b110001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1);
        wait_idle("busy_removf", 1);

        issue(6'b000000, 32'd3, 32'd4, 32'd0, 0, 0);
        @(negedge clk);
        check("ign_busy", 64'(busy), 64'd0);
        check("ign_result", 64'(result), 64'(last_res));

        issue(6'b000001, 32'd5, 32'd6, 32'd30, 34, 1);
        repeat (4) @(posedge clk);
        #1;
        start   = 1'b1;
        alu_sel = 6'b000001;
        op_a    = 32'h11;
        op_b    = 32'h22;
        @(posedge clk);
        #1;
        start   = 1'b0;
        alu_sel = '0;
        wait_idle("busy_mul2", 29);
        repeat (3) @(negedge clk);
        check("mul2_hold", 64'(result), 64'd30);

        issue(6'b101001, 32'd1000, 32'd9, 32'd0, 0, 0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_result", 64'(result), 64'd0);

        issue(6'b101001, 32'd9, 32'd3, 32'd3, 34, 1);
        wait_idle("busy_divu2", 34);
        repeat (2) @(negedge clk);
        check("queue_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
